// File: rtl/mesh_cfg_pkg.sv
// Shared types and the XY route-header encoding for the switch mesh configuration network.
package mesh_cfg_pkg;

  localparam int PKT_W  = 128;
  localparam int HDR_W  = 24;
  localparam int BODY_W = 104;

  typedef enum logic [1:0] {
    SOUTH = 2'd0,
    EAST  = 2'd1,
    NORTH = 2'd2,
    WEST  = 2'd3
  } port_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_FLIGHT = 3'd2,
    ST_DONE   = 3'd3,
    ST_DROP   = 3'd4
  } seq_state_t;

  // MSB first: col ones (east), row zeros (south), terminating one, zero fill.
  function automatic logic [HDR_W-1:0] route_header(input logic [3:0] row, input logic [3:0] col);
    logic [HDR_W-1:0] h;
    int stop;
    h    = '0;
    stop = int'(col) + int'(row);
    for (int i = 0; i < HDR_W; i++) begin
      if (i < int'(col) || i == stop) h[HDR_W-1-i] = 1'b1;
    end
    return h;
  endfunction

endpackage

// File: rtl/mesh_route_encoder.sv
// Combinational row/col to route header; also usable by mesh-side packet checkers.
module mesh_route_encoder
  import mesh_cfg_pkg::*;
(
  input  logic [3:0]       row,
  input  logic [3:0]       col,
  output logic [HDR_W-1:0] header
);

  assign header = route_header(row, col);

endmodule

// File: rtl/mesh_config_sequencer.sv
// Serialises host config requests into single routed packets and holds the mesh load
// strobe for the packet's flight time; out-of-range targets are dropped and flagged.
module mesh_config_sequencer
  import mesh_cfg_pkg::*;
#(
  parameter int MESH_ROWS = 12,
  parameter int MESH_COLS = 12,
  parameter int HOP_LAT   = 2,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [3:0]        s_row,
  input  logic [3:0]        s_col,
  input  logic [BODY_W-1:0] s_body,
  output logic [PKT_W-1:0]  o_config,
  output logic              o_config_mux,
  output logic              o_load,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  delivered
);

  seq_state_t       state;
  logic [5:0]       flight;
  logic [5:0]       flight_init;
  logic [HDR_W-1:0] hdr;
  logic             in_range;

  mesh_route_encoder u_enc (
    .row    (s_row),
    .col    (s_col),
    .header (hdr)
  );

  assign in_range     = (int'(s_row) < MESH_ROWS) && (int'(s_col) < MESH_COLS);
  assign flight_init  = 6'((int'(s_row) + int'(s_col) + 1) * HOP_LAT - 1);
  assign s_ready      = (state == ST_IDLE);
  assign o_config_mux = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      flight    <= '0;
      o_config  <= '0;
      o_load    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      delivered <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s_valid) begin
            if (in_range) begin
              // Request is consumed here; later changes on the inputs are ignored.
              state    <= ST_ISSUE;
              o_config <= {hdr, s_body};
              o_load   <= 1'b1;
              flight   <= flight_init;
            end else begin
              state <= ST_DROP;
            end
          end
        end
        ST_ISSUE: begin
          o_config <= '0;
          if (flight == 6'd0) begin
            state     <= ST_DONE;
            o_load    <= 1'b0;
            done      <= 1'b1;
            delivered <= delivered + CNT_W'(1);
          end else begin
            state <= ST_FLIGHT;
          end
        end
        ST_FLIGHT: begin
          flight <= flight - 6'd1;
          if (flight == 6'd1) begin
            state     <= ST_DONE;
            o_load    <= 1'b0;
            done      <= 1'b1;
            delivered <= delivered + CNT_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_DROP: begin
          err   <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_config_sequencer.sv
// Directed bench for mesh_config_sequencer with hand-computed headers and timing.
module tb_mesh_config_sequencer;
  import mesh_cfg_pkg::*;

  localparam int TB_CNT_W = 5;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic [3:0]          s_row = '0;
  logic [3:0]          s_col = '0;
  logic [BODY_W-1:0]   s_body = '0;
  logic [PKT_W-1:0]    o_config;
  logic                o_config_mux;
  logic                o_load;
  logic                done;
  logic                err;
  logic [TB_CNT_W-1:0] delivered;

  int checks = 0;
  int errors = 0;
  int exp_del = 0;

  // {o_load, s_ready, done} for cycles t+1..t+7 with s_valid held on (0,1) requests.
  logic [2:0] exp_b2b [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  mesh_config_sequencer #(
    .MESH_ROWS (12),
    .MESH_COLS (12),
    .HOP_LAT   (2),
    .CNT_W     (TB_CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_row        (s_row),
    .s_col        (s_col),
    .s_body       (s_body),
    .o_config     (o_config),
    .o_config_mux (o_config_mux),
    .o_load       (o_load),
    .done         (done),
    .err          (err),
    .delivered    (delivered)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Independent walk of a header through the mesh; returns {row,col} of the consuming switch.
  function automatic logic [7:0] walk(input logic [23:0] h);
    logic [3:0] r = 4'd0;
    logic [3:0] c = 4'd0;
    for (int i = 0; i < 24; i++) begin
      if (h == 24'h800000) return {r, c};
      if (h[23]) c++;
      else r++;
      h = h << 1;
    end
    return 8'hFF;
  endfunction

  task automatic send(input string tag, input logic [3:0] r, input logic [3:0] c,
                      input logic [103:0] body, input logic [23:0] exp_hdr,
                      input int exp_load, output logic [127:0] pkt);
    int   n;
    logic zero_ok;
    s_row = r; s_col = c; s_body = body; s_valid = 1'b1;
    chk({tag, "_ready"}, s_ready, 1);
    tick;
    s_valid = 1'b0; s_row = 4'hF; s_col = 4'hF; s_body = ~body;
    pkt = o_config;
    chk({tag, "_pkt"}, o_config, {exp_hdr, body});
    n = 0;
    zero_ok = 1'b1;
    while (o_load === 1'b1 && n < 200) begin
      if (n > 0 && o_config !== '0) zero_ok = 1'b0;
      n++;
      tick;
    end
    chk({tag, "_load_cycles"}, n, exp_load);
    chk({tag, "_flight_zero"}, zero_ok, 1);
    chk({tag, "_done"}, done, 1);
    exp_del++;
    chk({tag, "_delivered"}, delivered, TB_CNT_W'(exp_del));
    tick;
    chk({tag, "_done_clr"}, done, 0);
    chk({tag, "_ready_again"}, s_ready, 1);
  endtask

  initial begin
    logic [127:0] pkt;
    int           n;
    int           nd;
    logic         quiet;

    reset = 1'b1;
    tick;
    tick;
    chk("rst_config", o_config, 0);
    chk("rst_load", o_load, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_delivered", delivered, 0);
    chk("rst_mux", o_config_mux, 0);
    reset = 1'b0;
    tick;
    chk("idle_ready", s_ready, 1);

    send("r0c0", 4'd0, 4'd0, 104'h1, 24'h800000, 2, pkt);
    chk("r0c0_walk", walk(pkt[127:104]), 8'h00);

    send("r11c11", 4'd11, 4'd11, 104'hDEAD_BEEF_0123_4567_89AB_CDEF_55, 24'hFFE002, 46, pkt);
    chk("r11c11_walk", walk(pkt[127:104]), 8'hBB);

    // Out-of-range row: dropped, err set, nothing loaded.
    s_row = 4'd12; s_col = 4'd0; s_body = 104'h99; s_valid = 1'b1;
    chk("drop_ready", s_ready, 1);
    tick;
    s_valid = 1'b0;
    chk("drop_t1_load", o_load, 0);
    chk("drop_t1_ready", s_ready, 0);
    tick;
    chk("drop_t2_err", err, 1);
    chk("drop_t2_ready", s_ready, 1);
    chk("drop_t2_done", done, 0);
    chk("drop_t2_load", o_load, 0);
    chk("drop_delivered", delivered, TB_CNT_W'(exp_del));

    send("r1c2", 4'd1, 4'd2, 104'h4242, 24'hD00000, 8, pkt);
    chk("r1c2_walk", walk(pkt[127:104]), 8'h12);
    chk("r1c2_err_sticky", err, 1);

    // Back-to-back (0,1) requests with s_valid held: F = 3.
    s_row = 4'd0; s_col = 4'd1; s_body = 104'h55; s_valid = 1'b1;
    chk("b2b_ready", s_ready, 1);
    for (int k = 0; k < 7; k++) begin
      tick;
      chk($sformatf("b2b_cycle%0d", k + 1), {o_load, s_ready, done}, exp_b2b[k]);
      if (k == 0) chk("b2b_hdr", o_config[127:104], 24'hC00000);
    end
    s_valid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      n++;
      tick;
    end
    chk("b2b_second_done", done, 1);
    exp_del += 2;
    chk("b2b_delivered", delivered, TB_CNT_W'(exp_del));
    tick;

    // Reset in the middle of a (5,5) flight.
    s_row = 4'd5; s_col = 4'd5; s_body = 104'h77; s_valid = 1'b1;
    tick;
    s_valid = 1'b0;
    chk("r5c5_hdr", o_config[127:104], 24'hF82000);
    repeat (5) tick;
    chk("r5c5_inflight", o_load, 1);
    reset = 1'b1;
    tick;
    chk("midrst_load", o_load, 0);
    chk("midrst_config", o_config, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_delivered", delivered, 0);
    reset = 1'b0;
    exp_del = 0;
    chk("midrst_idle", s_ready, 1);
    quiet = 1'b1;
    repeat (30) begin
      tick;
      if (done !== 1'b0 || o_load !== 1'b0) quiet = 1'b0;
    end
    chk("midrst_quiet", quiet, 1);

    // Counter wrap: 2^TB_CNT_W (0,0) deliveries.
    s_row = 4'd0; s_col = 4'd0; s_body = 104'h1; s_valid = 1'b1;
    nd = 0;
    n = 0;
    while (nd < 32 && n < 400) begin
      tick;
      n++;
      if (done === 1'b1) begin
        nd++;
        if (nd == 31) chk("wrap_max", delivered, 31);
        if (nd == 32) s_valid = 1'b0;
      end
    end
    chk("wrap_count", nd, 32);
    chk("wrap_zero", delivered, 0);
    chk("wrap_err", err, 0);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
